// File: rtl/pipe_preif_if.sv
// Handshake from preIF to IF together with the instruction-SRAM request.
// preIF is the master: it offers a PC, and IF answers with allowin.
interface pipe_preif_if;
    logic        to_allowin;
    logic        to_valid;
    logic [31:0] to_pc;
    logic        inst_sram_en;
    logic [31:0] inst_sram_addr;

    modport master (
        input  to_allowin,
        output to_valid,
        output to_pc,
        output inst_sram_en,
        output inst_sram_addr
    );

    modport slave (
        output to_allowin,
        input  to_valid,
        input  to_pc,
        input  inst_sram_en,
        input  inst_sram_addr
    );
endinterface

// File: rtl/pipe_preif.sv
// Pre-fetch stage: picks the next fetch PC (ex > ertn > branch > PC+4), parks redirects
// while IF stalls. Optional PREIF_PERF_CNT_EN adds fetch/redirect counters.
module pipe_preif #(
    parameter logic [31:0] RESET_PC = 32'h1c000000,
    parameter int unsigned PC_INC   = 4
) (
    input  logic                clk,
    input  logic                reset,
    pipe_preif_if.master        fetch,
    input  logic                br_taken,
    input  logic [31:0]         br_target,
    input  logic                ex_WB,
    input  logic [31:0]         ex_entry,
    input  logic                flush_WB,
    input  logic [31:0]         ertn_pc
`ifdef PREIF_PERF_CNT_EN
    ,
    output logic [31:0]         fetch_cnt,
    output logic [31:0]         redir_cnt
`endif
);

    typedef enum logic [1:0] {StBoot, StRun, StPend} state_e;

    state_e      state_q, state_d;
    logic [31:0] seq_pc_q, seq_pc_d;
    logic        pend_vld_q, pend_vld_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic [1:0]  pend_kind_q, pend_kind_d;

    logic [1:0]  live_kind;
    logic [31:0] live_pc;
    logic [1:0]  eff_pend_kind;
    logic        live_ok;
    logic        fire;
    logic [31:0] next_pc;

    always_comb begin
        live_kind = 2'd0;
        live_pc   = br_target;
        if (ex_WB) begin
            live_kind = 2'd3;
            live_pc   = ex_entry;
        end else if (flush_WB) begin
            live_kind = 2'd2;
            live_pc   = ertn_pc;
        end else if (br_taken) begin
            live_kind = 2'd1;
            live_pc   = br_target;
        end
    end

    // A stale kind must not block a redirect once the pending slot is empty.
    assign eff_pend_kind = pend_vld_q ? pend_kind_q : 2'd0;
    assign live_ok = (state_q != StBoot) && (live_kind != 2'd0) && (live_kind >= eff_pend_kind);

    always_comb begin
        next_pc = seq_pc_q + 32'(PC_INC);
        if (reset) begin
            next_pc = RESET_PC;
        end else if (live_ok) begin
            next_pc = live_pc;
        end else if (pend_vld_q) begin
            next_pc = pend_pc_q;
        end
    end

    assign fetch.to_valid       = !reset && (state_q != StBoot);
    assign fetch.to_pc          = next_pc;
    assign fire                 = fetch.to_valid && fetch.to_allowin;
    assign fetch.inst_sram_en   = fire;
    assign fetch.inst_sram_addr = next_pc;

    always_comb begin
        state_d     = state_q;
        seq_pc_d    = seq_pc_q;
        pend_vld_d  = pend_vld_q;
        pend_pc_d   = pend_pc_q;
        pend_kind_d = pend_kind_q;
        unique case (state_q)
            StBoot: state_d = StRun;
            StRun, StPend: begin
                if (fire) begin
                    // A live redirect is consumed here directly, never parked.
                    seq_pc_d    = next_pc;
                    pend_vld_d  = 1'b0;
                    pend_kind_d = 2'd0;
                    state_d     = StRun;
                end else if (live_kind != 2'd0) begin
                    if (live_ok) begin
                        pend_vld_d  = 1'b1;
                        pend_pc_d   = live_pc;
                        pend_kind_d = live_kind;
                    end
                    state_d = StPend;
                end
            end
            default: state_d = StBoot;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StBoot;
            seq_pc_q    <= RESET_PC - 32'(PC_INC);
            pend_vld_q  <= 1'b0;
            pend_pc_q   <= '0;
            pend_kind_q <= 2'd0;
        end else begin
            state_q     <= state_d;
            seq_pc_q    <= seq_pc_d;
            pend_vld_q  <= pend_vld_d;
            pend_pc_q   <= pend_pc_d;
            pend_kind_q <= pend_kind_d;
        end
    end

`ifdef PREIF_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, redir_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_cnt_q <= '0;
            redir_cnt_q <= '0;
        end else begin
            if (fire) fetch_cnt_q <= fetch_cnt_q + 32'd1;
            // live_ok covers both a parked write and a redirect taken on fire.
            if (live_ok) redir_cnt_q <= redir_cnt_q + 32'd1;
        end
    end

    assign fetch_cnt = fetch_cnt_q;
    assign redir_cnt = redir_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_preif.sv
// Scoreboard bench for pipe_preif: stimulus queues expected fetch PCs, a negedge monitor
// pops and compares on every fire.
module tb_pipe_preif;
    localparam logic [31:0] RST_PC = 32'h1c000000;

    logic        clk = 1'b0;
    logic        reset;
    logic        br_taken, ex_WB, flush_WB;
    logic [31:0] br_target, ex_entry, ertn_pc;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    pipe_preif_if pif ();

    pipe_preif dut (
        .clk       (clk),
        .reset     (reset),
        .fetch     (pif),
        .br_taken  (br_taken),
        .br_target (br_target),
        .ex_WB     (ex_WB),
        .ex_entry  (ex_entry),
        .flush_WB  (flush_WB),
        .ertn_pc   (ertn_pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic redir(input logic allow, input logic br, input logic [31:0] bt,
                         input logic ex, input logic [31:0] ee,
                         input logic fl, input logic [31:0] ep);
        pif.to_allowin = allow;
        br_taken  = br;
        br_target = bt;
        ex_WB     = ex;
        ex_entry  = ee;
        flush_WB  = fl;
        ertn_pc   = ep;
        #1;
    endtask

    task automatic idle(input logic allow);
        redir(allow, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic expect_fire(input logic [31:0] pc);
        exp_q.push_back(pc);
        tick();
    endtask

    // Monitor: every fire presented by the DUT is matched against the scoreboard.
    always @(negedge clk) begin
        if (!reset && pif.to_valid && pif.to_allowin) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_fire: got pc %h expected no fire", pif.to_pc);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                check("fire_pc", pif.to_pc, e);
                check("sram_addr", pif.inst_sram_addr, e);
                check("sram_en", {31'd0, pif.inst_sram_en}, 32'd1);
            end
        end
    end

    initial begin
        reset = 1'b1;
        idle(1'b1);
        tick();
        tick();
        check("rst_valid", {31'd0, pif.to_valid}, 32'd0);
        check("rst_sram_en", {31'd0, pif.inst_sram_en}, 32'd0);
        check("rst_pc", pif.to_pc, RST_PC);

        // Boot cycle: no valid PC, redirect ignored.
        reset = 1'b0;
        redir(1'b1, 1'b1, 32'h1c000f00, 1'b0, 32'h0, 1'b0, 32'h0);
        check("boot_valid", {31'd0, pif.to_valid}, 32'd0);
        check("boot_pc", pif.to_pc, RST_PC);
        tick();
        idle(1'b1);
        expect_fire(32'h1c000000);
        expect_fire(32'h1c000004);
        expect_fire(32'h1c000008);

        // Branch taken while IF accepts: zero-latency redirect.
        redir(1'b1, 1'b1, 32'h1c000100, 1'b0, 32'h0, 1'b0, 32'h0);
        expect_fire(32'h1c000100);
        idle(1'b1);
        expect_fire(32'h1c000104);

        // Branch during a stall is parked and held.
        redir(1'b0, 1'b1, 32'h1c000200, 1'b0, 32'h0, 1'b0, 32'h0);
        check("stall_br_pc", pif.to_pc, 32'h1c000200);
        tick();
        idle(1'b0);
        for (int i = 0; i < 3; i++) begin
            check("stall_hold_pc", pif.to_pc, 32'h1c000200);
            check("stall_valid", {31'd0, pif.to_valid}, 32'd1);
            tick();
        end
        idle(1'b1);
        expect_fire(32'h1c000200);
        expect_fire(32'h1c000204);

        // Pending exception is not overridden by a later branch.
        redir(1'b0, 1'b0, 32'h0, 1'b1, 32'h1c008000, 1'b0, 32'h0);
        tick();
        redir(1'b0, 1'b1, 32'h1c000300, 1'b0, 32'h0, 1'b0, 32'h0);
        check("ex_over_br_pc", pif.to_pc, 32'h1c008000);
        tick();
        idle(1'b1);
        expect_fire(32'h1c008000);
        expect_fire(32'h1c008004);

        // Simultaneous ex, ertn, branch: exception wins.
        redir(1'b1, 1'b1, 32'h1c000300, 1'b1, 32'h1c008000, 1'b1, 32'h1c000040);
        expect_fire(32'h1c008000);
        idle(1'b1);
        expect_fire(32'h1c008004);

        // ertn beats branch.
        redir(1'b1, 1'b1, 32'h1c000300, 1'b0, 32'h0, 1'b1, 32'h1c000040);
        expect_fire(32'h1c000040);
        idle(1'b1);
        expect_fire(32'h1c000044);

        // Pending branch replaced by a later exception.
        redir(1'b0, 1'b1, 32'h1c000600, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        redir(1'b0, 1'b0, 32'h0, 1'b1, 32'h1c00a000, 1'b0, 32'h0);
        tick();
        idle(1'b1);
        expect_fire(32'h1c00a000);

        // Sequential wrap at the top of the address space.
        redir(1'b1, 1'b1, 32'hfffffffc, 1'b0, 32'h0, 1'b0, 32'h0);
        expect_fire(32'hfffffffc);
        idle(1'b1);
        expect_fire(32'h00000000);
        expect_fire(32'h00000004);

        // Plain stall: PC holds.
        idle(1'b0);
        tick();
        check("plain_stall_pc", pif.to_pc, 32'h00000008);
        tick();
        idle(1'b1);
        expect_fire(32'h00000008);

        // Reset while a redirect is pending discards it.
        redir(1'b0, 1'b1, 32'h1c000500, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        idle(1'b0);
        check("pend_pc", pif.to_pc, 32'h1c000500);
        reset = 1'b1;
        #1;
        check("rst_pend_valid", {31'd0, pif.to_valid}, 32'd0);
        tick();
        reset = 1'b0;
        idle(1'b1);
        check("reboot_valid", {31'd0, pif.to_valid}, 32'd0);
        tick();
        expect_fire(32'h1c000000);
        expect_fire(32'h1c000004);

        idle(1'b0);
        tick();
        tick();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_preif.md
Name: pipe_preif

Overview:
- Pre-fetch (preIF) stage. Produces the next fetch PC and drives the instruction-SRAM request.
- Hands the PC to the IF stage over the valid/allowin handshake, where IF is the receiver.
- Selects the next PC from, in priority order: exception entry, ertn return, branch target, sequential PC+4.
- Buffers a redirect that arrives while IF cannot accept, so no redirect is ever lost.

Parameters:
- RESET_PC, 32'h1c000000, PC of the first instruction fetched after reset.
- PC_INC, 4, sequential increment in bytes.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- to_allowin  input  1  IF stage can accept a PC this cycle
- to_valid  output  1  preIF holds a valid PC for IF
- to_pc  output  32  PC offered to IF
- br_taken  input  1  branch/jump resolved taken in ID/EX
- br_target  input  32  branch target
- ex_WB  input  1  exception reached WB
- ex_entry  input  32  exception entry address (CSR EENTRY)
- flush_WB  input  1  ertn reached WB
- ertn_pc  input  32  return address (CSR ERA)
- inst_sram_en  output  1  instruction SRAM read enable
- inst_sram_addr  output  32  instruction SRAM read address

Behaviour:
- Registers:
  - seq_pc (32): PC last handed to IF. Reset value RESET_PC-PC_INC.
  - pend_vld (1), pend_pc (32), pend_kind (2): 0=none, 1=br, 2=ertn, 3=ex.
  - state: BOOT, RUN, PEND.
- Reset: state=BOOT, pend_vld=0, to_valid=0, inst_sram_en=0. to_pc and inst_sram_addr show RESET_PC.
- BOOT:
  - to_valid=0 for exactly one cycle after reset deasserts.
  - Then go to RUN. Redirect inputs are ignored in BOOT.
- to_valid is 1 in RUN and PEND.
- fire = to_valid & to_allowin. On fire, IF latches to_pc on the same edge.
- Live redirect select, combinational:
  - ex_WB → ex_entry, else flush_WB → ertn_pc, else br_taken → br_target.
  - Its kind is 3/2/1 respectively.
- to_pc, in priority order:
  1. Live redirect whose kind ≥ pend_kind.
  2. Else pend_pc if pend_vld.
  3. Else seq_pc+PC_INC. Addition is mod 2^32; 0xFFFFFFFC wraps to 0x00000000.
- inst_sram_en = fire; inst_sram_addr = to_pc. Synchronous SRAM data is returned to IF in the following cycle.
- On fire: seq_pc <= to_pc, pend_vld <= 0, state <= RUN. This holds even if a redirect is live: the redirect is consumed directly, zero-cycle latency.
- Redirect live without fire:
  - Write pend_pc/pend_kind only if the new kind ≥ pend_kind. A branch never overwrites a pending ex/ertn; an ex overwrites anything.
  - state <= PEND.
- PEND:
  - to_pc = pend_pc, unless overridden per the rule above.
  - Stay in PEND until fire, then go to RUN.
- Simultaneous ex_WB+flush_WB+br_taken: ex wins. ertn beats br.
- to_allowin=0 indefinitely: to_pc is stable. seq_pc is unchanged.
- Reset mid-PEND: the pending redirect is discarded and fetch restarts at RESET_PC.
- Misaligned redirect targets are passed through unchanged; IF flags ADEF.

Optional Feature:
- Macro PREIF_PERF_CNT_EN.
- When defined, adds two outputs, both reset to 0, wrapping at 2^32, and not otherwise observable:
  - fetch_cnt[31:0]: increments on every fire.
  - redir_cnt[31:0]: increments on each cycle that writes pend_* or consumes a live redirect on fire.
- When undefined, these ports and counters are absent and the rest of the behaviour is identical.

Test Plan:
- Reset, then to_allowin=1 constantly → to_valid rises 1 cycle after reset drops. Fires carry 0x1c000000, 0x1c000004, 0x1c000008; inst_sram_addr is equal to each.
- to_allowin=1, br_taken=1 with br_target=0x1c000100 for one cycle → that cycle fires 0x1c000100, then 0x1c000104.
- to_allowin=0, br_taken pulse with target 0x1c000200, hold 3 cycles, then to_allowin=1 → to_pc=0x1c000200 throughout the stall. Fires once, then 0x1c000204.
- to_allowin=0; ex_WB pulse with entry 0x1c008000; next cycle br_taken pulse with target 0x1c000300; then to_allowin=1 → fires 0x1c008000, i.e. the branch does not override the exception.
- Same cycle ex_WB (entry 0x1c008000), flush_WB (era 0x1c000040), br_taken, with to_allowin=1 → fires 0x1c008000.
- seq_pc forced via a redirect to 0xFFFFFFFC, then sequential → next fire 0x00000000. Assert reset while in PEND → the next fire after BOOT is 0x1c000000.
